id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameters: DW, 32, datapath width; CW, 16, statistics counter width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have ports: rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 SHALL have ports: FlushE  in  1  insert bubble into Execute (hazard-unit output).
REQ-005 SHALL have ports: StallE  in  1  hold Execute contents (multicycle-unit hook; tie 0 if unused).
REQ-006 SHALL have ports: RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  Decode control.
REQ-007 SHALL have ports: ALUControlD  in  3  Decode ALU op.
REQ-008 SHALL have ports: RD1D, RD2D, SignImmD  in  DW each  Decode operands.
REQ-009 SHALL have ports: RsD, RtD, RdD  in  5 each  Decode register numbers.
REQ-010 SHALL have ports: matching *E outputs for every *D input above, same widths, registered.
REQ-011 SHALL have ports: ValidE  out  1  Execute slot holds a real instruction (0 = bubble).
REQ-012 SHALL have ports: BubbleCnt, HoldCnt  out  CW each  statistics (see Configuration).

Function
REQ-013 SHALL update all *E outputs on each clk rising edge; latency exactly 1 cycle D->E.
REQ-014 SHALL, when FlushE=1, load RegWriteE=MemToRegE=MemWriteE=0, ValidE=0, RsE=RtE=RdE=0; datapath fields (RD1E, RD2E, SignImmE, ALUControlE, ALUSrcE, RegDstE) SHALL also load 0.
REQ-015 SHALL, when StallE=1 and FlushE=0, hold every *E output and ValidE unchanged.
REQ-016 SHALL give FlushE priority over StallE when both are 1 (bubble inserted).
REQ-017 SHALL, when FlushE=0 and StallE=0, load every *D value and set ValidE=1.
REQ-018 SHALL guarantee a bubble never asserts RegWriteE/MemWriteE, and RsE/RtE=0, so zero-register forwarding guards never match.
REQ-019 SHALL treat X/Z on FlushE or StallE as no special case; the block contains no X-detection logic.
REQ-020 SHALL, with statistics enabled, increment BubbleCnt on each non-reset cycle with FlushE=1, and HoldCnt on each non-reset cycle with StallE=1 and FlushE=0.
REQ-021 SHALL saturate each counter at 2^CW-1 (no wrap); increments stop at all-ones.

Reset
REQ-022 SHALL, on clk edge with rst_n=0, clear every *E output, ValidE, BubbleCnt and HoldCnt to 0, overriding FlushE/StallE.
REQ-023 SHALL resume normal loading on the first edge with rst_n=1; reset asserted mid-stall discards the held instruction.
REQ-024 SHALL contain no initial blocks; reset is the only initialisation mechanism.

Configuration
REQ-025 SHALL compile statistics counters only when macro ID_EX_STATS_EN is defined.
REQ-026 SHALL, without ID_EX_STATS_EN, drive BubbleCnt and HoldCnt constant 0 and instantiate no counter flops; port list unchanged.

Structure
REQ-027 SHALL take ALUControl encoding width (3) and register-number width (5) from shared package mips_pkg, with the control-bundle struct/typedef defined there.
REQ-028 SHALL use one sub-module, sat_counter (CW-bit saturating counter with enable and synchronous active-low clear), instantiated twice under ID_EX_STATS_EN.
REQ-029 SHALL keep all pipeline-register logic in a single clocked process; no combinational path from any input to any output.

Verification
REQ-030 SHALL cover pass-through: RegWriteD=1, RsD=5, RD1D=32'h1234 with FlushE=StallE=0 -> next edge RegWriteE=1, RsE=5, RD1E=32'h1234, ValidE=1.
REQ-031 SHALL cover flush: FlushE=1 with RegWriteD=1, MemWriteD=1, RsD=9 -> next edge RegWriteE=0, MemWriteE=0, RsE=0, ValidE=0, BubbleCnt+1.
REQ-032 SHALL cover stall: load RtD=7, then StallE=1 for 3 cycles while RtD=12 -> RtE stays 7, HoldCnt=3, then RtE=12 one cycle after StallE drops.
REQ-033 SHALL cover priority: FlushE=1 and StallE=1 together -> bubble loaded, HoldCnt unchanged, BubbleCnt+1.
REQ-034 SHALL cover reset mid-stall: StallE=1 holding RsE=3, rst_n=0 one edge -> all outputs 0; with CW=4, 20 flush cycles -> BubbleCnt=15.
REQ-035 SHALL cover macro off: ID_EX_STATS_EN undefined, 10 flush cycles -> BubbleCnt=HoldCnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU-op and register-number widths and
// the Decode/Execute control bundle carried through the ID/EX register.
package mips_pkg;

   localparam int unsigned ALU_W = 3;   // ALUControl encoding width
   localparam int unsigned REG_W = 5;   // register-number width

   // Control bundle that travels with each instruction from Decode to Execute.
   typedef struct packed {
      logic             reg_write;
      logic             mem_to_reg;
      logic             mem_write;
      logic             alu_src;
      logic             reg_dst;
      logic [ALU_W-1:0] alu_control;
   } ctrl_t;

endpackage

// File: rtl/id_ex_reg_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports: clk, clr_n (synchronous active-low clear), en (count enable),
//        cnt (registered count).
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_d, cnt_q;

   // Next count: hold unless enabled and not yet saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: MIPS Decode->Execute pipeline register with flush (bubble),
// stall (hold) and optional bubble/hold statistics counters.
// Ports: clk, rst_n (synchronous active-low); FlushE, StallE controls;
//        *D Decode control/operands/register numbers in, matching *E out;
//        ValidE (0 = bubble); BubbleCnt, HoldCnt statistics.
// Macro ID_EX_STATS_EN: when defined, builds the two saturating counters;
// otherwise BubbleCnt/HoldCnt are tied to 0.
module id_ex_reg
   import mips_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             FlushE,
   input  logic             StallE,
   input  logic             RegWriteD,
   input  logic             MemToRegD,
   input  logic             MemWriteD,
   input  logic             ALUSrcD,
   input  logic             RegDstD,
   input  logic [ALU_W-1:0] ALUControlD,
   input  logic [DW-1:0]    RD1D,
   input  logic [DW-1:0]    RD2D,
   input  logic [DW-1:0]    SignImmD,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic [REG_W-1:0] RdD,
   output logic             RegWriteE,
   output logic             MemToRegE,
   output logic             MemWriteE,
   output logic             ALUSrcE,
   output logic             RegDstE,
   output logic [ALU_W-1:0] ALUControlE,
   output logic [DW-1:0]    RD1E,
   output logic [DW-1:0]    RD2E,
   output logic [DW-1:0]    SignImmE,
   output logic [REG_W-1:0] RsE,
   output logic [REG_W-1:0] RtE,
   output logic [REG_W-1:0] RdE,
   output logic             ValidE,
   output logic [CW-1:0]    BubbleCnt,
   output logic [CW-1:0]    HoldCnt
);

   ctrl_t            ctrl_d, ctrl_q;
   logic [DW-1:0]    rd1_d, rd1_q;
   logic [DW-1:0]    rd2_d, rd2_q;
   logic [DW-1:0]    imm_d, imm_q;
   logic [REG_W-1:0] rs_d, rs_q;
   logic [REG_W-1:0] rt_d, rt_q;
   logic [REG_W-1:0] rd_d, rd_q;
   logic             valid_d, valid_q;

   // Next-state: hold by default; flush beats stall and zeroes the whole
   // slot so a bubble can never write or match a forwarding comparator.
   always_comb begin
      ctrl_d  = ctrl_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      if (FlushE) begin
         ctrl_d  = '0;
         rd1_d   = '0;
         rd2_d   = '0;
         imm_d   = '0;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         valid_d = 1'b0;
      end else if (!StallE) begin
         ctrl_d.reg_write   = RegWriteD;
         ctrl_d.mem_to_reg  = MemToRegD;
         ctrl_d.mem_write   = MemWriteD;
         ctrl_d.alu_src     = ALUSrcD;
         ctrl_d.reg_dst     = RegDstD;
         ctrl_d.alu_control = ALUControlD;
         rd1_d   = RD1D;
         rd2_d   = RD2D;
         imm_d   = SignImmD;
         rs_d    = RsD;
         rt_d    = RtD;
         rd_d    = RdD;
         valid_d = 1'b1;
      end
   end

   // Pipeline register; reset overrides flush/stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q  <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
      end
   end

   assign RegWriteE   = ctrl_q.reg_write;
   assign MemToRegE   = ctrl_q.mem_to_reg;
   assign MemWriteE   = ctrl_q.mem_write;
   assign ALUSrcE     = ctrl_q.alu_src;
   assign RegDstE     = ctrl_q.reg_dst;
   assign ALUControlE = ctrl_q.alu_control;
   assign RD1E        = rd1_q;
   assign RD2E        = rd2_q;
   assign SignImmE    = imm_q;
   assign RsE         = rs_q;
   assign RtE         = rt_q;
   assign RdE         = rd_q;
   assign ValidE      = valid_q;

`ifdef ID_EX_STATS_EN
   logic hold_en_c;

   // A stall only counts as a hold when it is not overridden by a flush.
   assign hold_en_c = StallE & ~FlushE;

   sat_counter #(.W(CW)) u_bubble_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .en    (FlushE),
      .cnt   (BubbleCnt)
   );

   sat_counter #(.W(CW)) u_hold_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .en    (hold_en_c),
      .cnt   (HoldCnt)
   );
`else
   assign BubbleCnt = '0;
   assign HoldCnt   = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg (CW=4 so saturation is reachable).
module tb_id_ex_reg;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic          clk, rst_n, FlushE, StallE;
   logic          RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD;
   logic [2:0]    ALUControlD;
   logic [DW-1:0] RD1D, RD2D, SignImmD;
   logic [4:0]    RsD, RtD, RdD;
   logic          RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
   logic [2:0]    ALUControlE;
   logic [DW-1:0] RD1E, RD2E, SignImmE;
   logic [4:0]    RsE, RtE, RdE;
   logic          ValidE;
   logic [CW-1:0] BubbleCnt, HoldCnt;

   id_ex_reg #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .FlushE(FlushE), .StallE(StallE),
      .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
      .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
      .RsE(RsE), .RtE(RtE), .RdE(RdE),
      .ValidE(ValidE), .BubbleCnt(BubbleCnt), .HoldCnt(HoldCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n, flush, stall;
      logic       rw, m2r, mw, alus, rdst;
      logic [2:0] aluc;
      logic [31:0] rd1, rd2, imm;
      logic [4:0] rs, rt, rd;
   } in_t;

   typedef struct packed {
      logic       valid, rw, m2r, mw, alus, rdst;
      logic [2:0] aluc;
      logic [31:0] rd1, rd2, imm;
      logic [4:0] rs, rt, rd;
   } pipe_t;

   typedef struct packed {
      pipe_t      p;
      logic [3:0] bc, hc;
   } exp_t;

   typedef struct {
      in_t  in;
      logic exp_valid;
   } vec_t;

   exp_t  sb_q[$];
   pipe_t m_p;
   int    m_bc, m_hc;
   int    n_chk, n_fail;
   localparam int SAT = 15;

`ifdef ID_EX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   function automatic in_t mk(logic f, logic s, logic rw, logic mw,
                              logic [4:0] rs, logic [4:0] rt, logic [31:0] rd1);
      in_t v;
      v.rst_n = 1'b1; v.flush = f; v.stall = s;
      v.rw = rw; v.m2r = rs[0]; v.mw = mw; v.alus = rt[0]; v.rdst = ~rs[1];
      v.aluc = rd1[2:0] ^ 3'b101;
      v.rd1 = rd1; v.rd2 = ~rd1; v.imm = rd1 ^ 32'h5a5a_0f0f;
      v.rs = rs; v.rt = rt; v.rd = rs + rt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent behavioural model of one clock edge.
   task automatic model(input in_t v);
      if (!v.rst_n) begin
         m_p = '0; m_bc = 0; m_hc = 0;
      end else if (v.flush) begin
         m_p = '0;
         if (m_bc < SAT) m_bc++;
      end else if (v.stall) begin
         if (m_hc < SAT) m_hc++;
      end else begin
         m_p = '{valid:1'b1, rw:v.rw, m2r:v.m2r, mw:v.mw, alus:v.alus, rdst:v.rdst,
                 aluc:v.aluc, rd1:v.rd1, rd2:v.rd2, imm:v.imm, rs:v.rs, rt:v.rt, rd:v.rd};
      end
   endtask

   // Drive one vector, push its expected result, clock, then compare.
   task automatic step(input in_t v);
      exp_t e, g;
      pipe_t act;
      rst_n = v.rst_n; FlushE = v.flush; StallE = v.stall;
      RegWriteD = v.rw; MemToRegD = v.m2r; MemWriteD = v.mw;
      ALUSrcD = v.alus; RegDstD = v.rdst; ALUControlD = v.aluc;
      RD1D = v.rd1; RD2D = v.rd2; SignImmD = v.imm;
      RsD = v.rs; RtD = v.rt; RdD = v.rd;
      model(v);
      e.p  = m_p;
      e.bc = STATS ? 4'(m_bc) : 4'd0;
      e.hc = STATS ? 4'(m_hc) : 4'd0;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      g = sb_q.pop_front();
      act = '{valid:ValidE, rw:RegWriteE, m2r:MemToRegE, mw:MemWriteE, alus:ALUSrcE,
              rdst:RegDstE, aluc:ALUControlE, rd1:RD1E, rd2:RD2E, imm:SignImmE,
              rs:RsE, rt:RtE, rd:RdE};
      chk("pipe", 128'(act), 128'(g.p));
      chk("counters", 128'({BubbleCnt, HoldCnt}), 128'({g.bc, g.hc}));
   endtask

   task automatic do_reset();
      in_t v;
      v = mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 32'hffff_ffff);
      v.rst_n = 1'b0;
      step(v);
   endtask

   vec_t tbl[7];
   logic [3:0] exp_sat;

   initial begin
      n_chk = 0; n_fail = 0;
      m_p = '0; m_bc = 0; m_hc = 0;
      exp_sat = STATS ? 4'd15 : 4'd0;

      tbl[0] = '{mk(0, 0, 1, 0, 5'd5,  5'd6,  32'h0000_1234), 1'b1};
      tbl[1] = '{mk(1, 0, 1, 1, 5'd9,  5'd3,  32'hdead_beef), 1'b0};
      tbl[2] = '{mk(0, 0, 0, 1, 5'd1,  5'd2,  32'hbeef_0001), 1'b1};
      tbl[3] = '{mk(0, 1, 1, 1, 5'd4,  5'd4,  32'h0000_0000), 1'b1};
      tbl[4] = '{mk(1, 1, 1, 1, 5'd7,  5'd7,  32'h0000_0077), 1'b0};
      tbl[5] = '{mk(0, 1, 1, 0, 5'd8,  5'd8,  32'h1111_2222), 1'b0};
      tbl[6] = '{mk(0, 0, 1, 1, 5'd31, 5'd31, 32'hffff_ffff), 1'b1};

      FlushE = 1'b0; StallE = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      do_reset();
      chk("reset_valid", 128'(ValidE), 128'(0));
      chk("reset_rd1", 128'(RD1E), 128'(0));

      // Table-driven vectors.
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].in);
         chk($sformatf("tbl%0d_valid", i), 128'(ValidE), 128'(tbl[i].exp_valid));
      end

      // Pass-through.
      step(mk(0, 0, 1, 0, 5'd5, 5'd0, 32'h0000_1234));
      chk("pass_rw", 128'(RegWriteE), 128'(1));
      chk("pass_rs", 128'(RsE), 128'(5));
      chk("pass_rd1", 128'(RD1E), 128'(32'h1234));
      chk("pass_valid", 128'(ValidE), 128'(1));

      // Flush.
      step(mk(1, 0, 1, 1, 5'd9, 5'd9, 32'h0000_9999));
      chk("flush_rw", 128'(RegWriteE), 128'(0));
      chk("flush_mw", 128'(MemWriteE), 128'(0));
      chk("flush_rs", 128'(RsE), 128'(0));
      chk("flush_valid", 128'(ValidE), 128'(0));

      // Stall for three cycles, then release.
      do_reset();
      step(mk(0, 0, 1, 0, 5'd2, 5'd7, 32'h0000_0007));
      for (int i = 0; i < 3; i++) begin
         step(mk(0, 1, 1, 0, 5'd2, 5'd12, 32'h0000_000c));
         chk("stall_rt", 128'(RtE), 128'(7));
      end
      chk("stall_hold", 128'(HoldCnt), 128'(STATS ? 4'd3 : 4'd0));
      step(mk(0, 0, 1, 0, 5'd2, 5'd12, 32'h0000_000c));
      chk("release_rt", 128'(RtE), 128'(12));

      // Flush and stall together.
      step(mk(1, 1, 1, 1, 5'd6, 5'd6, 32'h0000_0066));
      chk("prio_valid", 128'(ValidE), 128'(0));
      chk("prio_hold", 128'(HoldCnt), 128'(STATS ? 4'd3 : 4'd0));

      // Reset mid-stall discards the held instruction.
      step(mk(0, 0, 1, 1, 5'd3, 5'd1, 32'h0000_0333));
      step(mk(0, 1, 1, 1, 5'd4, 5'd1, 32'h0000_0444));
      chk("midstall_rs", 128'(RsE), 128'(3));
      do_reset();
      chk("rst_stall_rs", 128'(RsE), 128'(0));
      chk("rst_stall_valid", 128'(ValidE), 128'(0));

      // Twenty flushes saturate a 4-bit bubble counter.
      for (int i = 0; i < 20; i++) step(mk(1, 0, 1, 1, 5'(i), 5'(i), 32'(i)));
      chk("bubble_sat", 128'(BubbleCnt), 128'(exp_sat));
      chk("hold_after_flushes", 128'(HoldCnt), 128'(0));

      // Randomised mix.
      for (int i = 0; i < 60; i++) begin
         in_t v;
         v = mk(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), $urandom);
         if ($urandom_range(0, 29) == 0) v.rst_n = 1'b0;
         step(v);
      end

      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
